// File: rtl/spm_resp.sv
// Single-ported scratchpad shared by a fetch (IF) port and a data (MEM) port.
// MEM has fixed priority; a colliding IF request is rejected, not queued.
module spm_resp #(
   parameter int SPM_ADDR_W = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] if_spm_addr,
   input  logic        if_spm_as_,
   input  logic        if_spm_rw,
   input  logic [31:0] if_spm_wr_data,
   output logic [31:0] if_spm_rd_data,
   output logic        if_spm_busy,
   input  logic [29:0] mem_spm_addr,
   input  logic        mem_spm_as_,
   input  logic        mem_spm_rw,
   input  logic [31:0] mem_spm_wr_data,
   output logic [31:0] mem_spm_rd_data,
   output logic [15:0] conflict_cnt
);

   localparam int DEPTH = 1 << SPM_ADDR_W;

   logic [31:0]           ram_q [DEPTH];

   logic                  mem_req;
   logic                  if_req;
   logic                  if_acc;
   logic                  acc_we;
   logic [SPM_ADDR_W-1:0] acc_addr;
   logic [31:0]           acc_wdata;
   logic [31:0]           ram_rdata;

   logic [31:0]           if_rd_d,  if_rd_q;
   logic [31:0]           mem_rd_d, mem_rd_q;
   logic [15:0]           conflict_cnt_d, conflict_cnt_q;

   // Upper address bits are intentionally ignored so addresses alias modulo the depth.
   logic                  unused_addr_hi;
   assign unused_addr_hi = ^{if_spm_addr[29:SPM_ADDR_W], mem_spm_addr[29:SPM_ADDR_W]};

   always_comb begin
      mem_req     = !mem_spm_as_;
      if_req      = !if_spm_as_;
      if_spm_busy = if_req && mem_req;
      if_acc      = if_req && !mem_req;

      acc_addr  = mem_req ? mem_spm_addr[SPM_ADDR_W-1:0] : if_spm_addr[SPM_ADDR_W-1:0];
      acc_wdata = mem_req ? mem_spm_wr_data : if_spm_wr_data;
      acc_we    = !reset && ((mem_req && !mem_spm_rw) || (if_acc && !if_spm_rw));
      ram_rdata = ram_q[acc_addr];

      mem_rd_d = mem_rd_q;
      if (mem_req && mem_spm_rw) begin
         mem_rd_d = ram_rdata;
      end

      if_rd_d = if_rd_q;
      if (if_acc && if_spm_rw) begin
         if_rd_d = ram_rdata;
      end

      conflict_cnt_d = conflict_cnt_q;
      if (if_spm_busy && (conflict_cnt_q != 16'hFFFF)) begin
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
   end

   // Array has no reset: contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (acc_we) begin
         ram_q[acc_addr] <= acc_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if_rd_q        <= 32'd0;
         mem_rd_q       <= 32'd0;
         conflict_cnt_q <= 16'd0;
      end else begin
         if_rd_q        <= if_rd_d;
         mem_rd_q       <= mem_rd_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign if_spm_rd_data  = if_rd_q;
   assign mem_spm_rd_data = mem_rd_q;
   assign conflict_cnt    = conflict_cnt_q;

endmodule

// File: tb/tb_spm_resp.sv
// Self-checking bench for spm_resp: directed scenarios plus a randomized
// two-port stream checked against a word-array reference model.
module tb_spm_resp;

   localparam int AW    = 12;
   localparam int DEPTH = 1 << AW;

   logic        clk = 1'b0;
   logic        reset;
   logic [29:0] if_addr,  mem_addr;
   logic        if_as_,   mem_as_;
   logic        if_rw,    mem_rw;
   logic [31:0] if_wd,    mem_wd;
   logic [31:0] if_rd,    mem_rd;
   logic        if_busy;
   logic [15:0] cnt;

   int          n_checks = 0;
   int          n_fail   = 0;

   logic [31:0] model [int];
   logic [31:0] exp_if_rd, exp_mem_rd;
   int          exp_cnt;

   always #5 clk = ~clk;

   spm_resp #(.SPM_ADDR_W(AW)) dut (
      .clk             (clk),
      .reset           (reset),
      .if_spm_addr     (if_addr),
      .if_spm_as_      (if_as_),
      .if_spm_rw       (if_rw),
      .if_spm_wr_data  (if_wd),
      .if_spm_rd_data  (if_rd),
      .if_spm_busy     (if_busy),
      .mem_spm_addr    (mem_addr),
      .mem_spm_as_     (mem_as_),
      .mem_spm_rw      (mem_rw),
      .mem_spm_wr_data (mem_wd),
      .mem_spm_rd_data (mem_rd),
      .conflict_cnt    (cnt)
   );

   task automatic idle();
      if_as_  = 1'b1; if_rw  = 1'b1; if_addr  = '0; if_wd  = '0;
      mem_as_ = 1'b1; mem_rw = 1'b1; mem_addr = '0; mem_wd = '0;
   endtask

   task automatic mem_op(input logic rw, input logic [29:0] a, input logic [31:0] d);
      mem_as_ = 1'b0; mem_rw = rw; mem_addr = a; mem_wd = d;
   endtask

   task automatic if_op(input logic rw, input logic [29:0] a, input logic [31:0] d);
      if_as_ = 1'b0; if_rw = rw; if_addr = a; if_wd = d;
   endtask

   // Reference model: apply the currently driven request to the expectations.
   task automatic model_cycle();
      int idx;
      if (reset) begin
         exp_if_rd = 0; exp_mem_rd = 0; exp_cnt = 0;
         return;
      end
      if (!mem_as_) begin
         idx = int'(mem_addr) % DEPTH;
         if (mem_rw) exp_mem_rd = model[idx];
         else        model[idx] = mem_wd;
      end else if (!if_as_) begin
         idx = int'(if_addr) % DEPTH;
         if (if_rw) exp_if_rd = model[idx];
         else       model[idx] = if_wd;
      end
      if (!if_as_ && !mem_as_ && exp_cnt < 65535) exp_cnt++;
   endtask

   task automatic cycle();
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; idle(); cycle(); reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; idle();
      mem_op(1'b0, 30'd0, 32'h77);
      if_op(1'b1, 30'd1, 32'h0);
      #1;
      n_checks++;
      if (if_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", if_busy); end
      cycle();
      reset = 1'b0; idle();
      n_checks++;
      if (if_rd !== 32'd0 || mem_rd !== 32'd0 || cnt !== 16'd0) begin
         n_fail++; $display("FAIL reset_state: if_rd=%h mem_rd=%h cnt=%h want 0", if_rd, mem_rd, cnt);
      end
   endtask

   task automatic test_init();
      for (int i = 0; i < 16; i++) begin
         idle(); mem_op(1'b0, 30'(i), $urandom); cycle();
      end
      idle(); mem_op(1'b0, 30'hFFF, $urandom); cycle();
      idle();
   endtask

   task automatic test_write_read();
      idle(); mem_op(1'b0, 30'd5, 32'hDEADBEEF); cycle();
      idle(); mem_op(1'b1, 30'd5, 32'h0); cycle();
      idle();
      n_checks++;
      if (mem_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_read: got %h want deadbeef", mem_rd); end
   endtask

   task automatic test_conflict();
      do_reset();
      idle();
      if_op(1'b1, 30'd8, 32'h0);
      mem_op(1'b0, 30'd8, 32'h12345678);
      #1;
      n_checks++;
      if (if_busy !== 1'b1) begin n_fail++; $display("FAIL conflict_busy: got %b want 1", if_busy); end
      cycle();
      n_checks++;
      if (cnt !== 16'd1 || if_rd !== 32'd0) begin
         n_fail++; $display("FAIL conflict_cnt: cnt=%h if_rd=%h want cnt 1 if_rd 0", cnt, if_rd);
      end
      idle(); if_op(1'b1, 30'd8, 32'h0);
      #1;
      n_checks++;
      if (if_busy !== 1'b0) begin n_fail++; $display("FAIL retry_busy: got %b want 0", if_busy); end
      cycle();
      idle();
      n_checks++;
      if (if_rd !== 32'h12345678 || cnt !== 16'd1) begin
         n_fail++; $display("FAIL retry_read: if_rd=%h cnt=%h want 12345678 / 1", if_rd, cnt);
      end
   endtask

   task automatic test_hold();
      idle(); mem_op(1'b0, 30'd3, 32'hA5A5A5A5); cycle();
      idle(); if_op(1'b1, 30'd3, 32'h0); cycle();
      idle();
      for (int i = 0; i < 4; i++) begin
         cycle();
         n_checks++;
         if (if_rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL hold[%0d]: got %h want a5a5a5a5", i, if_rd); end
      end
   endtask

   task automatic test_alias();
      idle(); mem_op(1'b0, 30'h1005, 32'h1); cycle();
      idle(); if_op(1'b1, 30'h0005, 32'h0); cycle();
      idle();
      n_checks++;
      if (if_rd !== 32'h1) begin n_fail++; $display("FAIL alias: got %h want 1", if_rd); end
   endtask

   task automatic test_top_index();
      idle(); mem_op(1'b0, 30'd0, 32'h11110000); cycle();
      idle(); mem_op(1'b0, 30'hFFF, 32'h2222FFFF); cycle();
      idle(); mem_op(1'b1, 30'd0, 32'h0); cycle();
      n_checks++;
      if (mem_rd !== 32'h11110000) begin n_fail++; $display("FAIL top_idx0: got %h want 11110000", mem_rd); end
      idle(); if_op(1'b1, 30'hFFF, 32'h0); cycle();
      idle();
      n_checks++;
      if (if_rd !== 32'h2222FFFF) begin n_fail++; $display("FAIL top_idxfff: got %h want 2222ffff", if_rd); end
   endtask

   task automatic test_reset_mid();
      idle(); mem_op(1'b0, 30'd2, 32'h0000CAFE); cycle();
      idle(); if_op(1'b1, 30'd2, 32'h0); cycle();
      reset = 1'b1; idle();
      mem_op(1'b0, 30'd2, 32'hFFFF0000);
      if_op(1'b1, 30'd2, 32'h0);
      cycle();
      reset = 1'b0; idle();
      n_checks++;
      if (if_rd !== 32'd0 || mem_rd !== 32'd0 || cnt !== 16'd0) begin
         n_fail++; $display("FAIL reset_mid_state: if_rd=%h mem_rd=%h cnt=%h want 0", if_rd, mem_rd, cnt);
      end
      mem_op(1'b1, 30'd2, 32'h0); cycle();
      idle();
      n_checks++;
      if (mem_rd !== 32'h0000CAFE) begin n_fail++; $display("FAIL reset_mid_keep: got %h want 0000cafe", mem_rd); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         idle();
         reset = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 1) == 1)
            mem_op(1'($urandom), (30'($urandom) & 30'h3FFF_F000) | 30'($urandom_range(0, 15)), $urandom);
         if ($urandom_range(0, 2) != 0)
            if_op(1'($urandom), (30'($urandom) & 30'h3FFF_F000) | 30'($urandom_range(0, 15)), $urandom);
         #1;
         n_checks++;
         if (if_busy !== (!if_as_ && !mem_as_)) begin
            n_fail++; $display("FAIL rand_busy[%0d]: got %b want %b", i, if_busy, (!if_as_ && !mem_as_));
         end
         cycle();
         n_checks++;
         if (if_rd !== exp_if_rd || mem_rd !== exp_mem_rd || cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL rand_out[%0d]: if_rd=%h/%h mem_rd=%h/%h cnt=%h/%h (got/want)",
                     i, if_rd, exp_if_rd, mem_rd, exp_mem_rd, cnt, 16'(exp_cnt));
         end
      end
      reset = 1'b0; idle();
   endtask

   task automatic test_saturation();
      do_reset();
      idle();
      mem_op(1'b1, 30'd0, 32'h0);
      if_op(1'b1, 30'd1, 32'h0);
      for (int i = 0; i < 65534; i++) cycle();
      n_checks++;
      if (cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre: got %h want fffe", cnt); end
      for (int i = 0; i < 6; i++) cycle();
      n_checks++;
      if (cnt !== 16'hFFFF || if_busy !== 1'b1) begin
         n_fail++; $display("FAIL sat: cnt=%h busy=%b want ffff / 1", cnt, if_busy);
      end
      n_checks++;
      if (if_rd !== exp_if_rd || mem_rd !== exp_mem_rd) begin
         n_fail++; $display("FAIL sat_rd: if_rd=%h/%h mem_rd=%h/%h (got/want)", if_rd, exp_if_rd, mem_rd, exp_mem_rd);
      end
      idle(); cycle();
      n_checks++;
      if (cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", cnt); end
   endtask

   initial begin
      exp_if_rd = 0; exp_mem_rd = 0; exp_cnt = 0;
      reset = 1'b0;
      idle();
      @(posedge clk); #1;
      test_reset();
      test_init();
      test_write_read();
      test_conflict();
      test_hold();
      test_alias();
      test_top_index();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
